// File: rtl/stack_machine_pkg.sv
// Shared opcodes, FSM states and Q-format defaults
// for the RPN stack machine used by the function plotter.
package stack_machine_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_BITS_DEF  = 8;
  localparam int SIZE_DEF       = 64;

  localparam logic [2:0] OP_PUSH_IMM = 3'd0;
  localparam logic [2:0] OP_PUSH_X   = 3'd1;
  localparam logic [2:0] OP_ADD      = 3'd2;
  localparam logic [2:0] OP_SUB      = 3'd3;
  localparam logic [2:0] OP_MUL      = 3'd4;
  localparam logic [2:0] OP_END      = 3'd7;

  typedef enum logic [1:0] {
    S_RUN,
    S_BINOP,
    S_ENDRD,
    S_DRAIN
  } state_t;

  function automatic logic is_push_op(input logic [2:0] op);
    return (op == OP_PUSH_IMM) || (op == OP_PUSH_X);
  endfunction

  function automatic logic is_bin_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/stack_machine_if.sv
// Instruction stream (valid/ready) plus result pulse.
// master: instruction producer / result consumer; slave: core.
interface stack_machine_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [2:0]            instr_opcode;
  logic [DATA_WIDTH-1:0] instr_imm;
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_error;

  modport master (
    output instr_valid, instr_opcode, instr_imm,
    input  instr_ready, result_valid, result, result_error
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_imm,
    output instr_ready, result_valid, result, result_error
  );
endinterface

// File: rtl/stack_machine_alu.sv
// Combinational ADD/SUB/MUL; a = top, b = second entry.
// MUL is signed fixed-point, shifted by FRAC_BITS, wrapping.
module stack_machine_alu
  import stack_machine_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] a_w;
  logic signed [PW-1:0] b_w;
  logic signed [PW-1:0] prod;

  assign a_w  = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign b_w  = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
  assign prod = b_w * a_w;

  always_comb begin
    y = b + a;
    unique case (op)
      OP_SUB:  y = b - a;
      OP_MUL:  y = DATA_WIDTH'(prod >>> FRAC_BITS);
      default: y = b + a;
    endcase
  end

endmodule

// File: rtl/stack_machine_mem.sv
// Dual-port stack RAM: port A read/write, port B read.
// Both reads registered; port A read only updates when not writing.
module stack_machine_mem #(
  parameter int  DATA_WIDTH = 16,
  parameter int  SIZE       = 64,
  localparam int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic                  a_write_enable,
  input  logic [DATA_WIDTH-1:0] a_write_data,
  output logic [DATA_WIDTH-1:0] a_read_data,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_read_data
);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (a_write_enable) begin
      mem[a_addr] <= a_write_data;
    end else begin
      a_read_data <= mem[a_addr];
    end
    b_read_data <= mem[b_addr];
  end

endmodule

// File: rtl/stack_machine_core.sv
// RPN evaluator: FSM, stack pointer and stack memory port muxing.
// Ports: clk/rst, bus (instr stream + result), x, stack mem A/B.
module stack_machine_core
  import stack_machine_pkg::*;
#(
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int  SIZE       = SIZE_DEF,
  parameter int  FRAC_BITS  = FRAC_BITS_DEF,
  localparam int ADDR_WIDTH = $clog2(SIZE),
  localparam int SP_WIDTH   = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  stack_machine_if.slave        bus,
  input  logic [DATA_WIDTH-1:0] x,
  output logic [ADDR_WIDTH-1:0] mem_a_addr,
  output logic                  mem_a_write_enable,
  output logic [DATA_WIDTH-1:0] mem_a_write_data,
  input  logic [DATA_WIDTH-1:0] mem_a_read_data,
  output logic [ADDR_WIDTH-1:0] mem_b_addr,
  input  logic [DATA_WIDTH-1:0] mem_b_read_data
);

  state_t                state;
  logic [SP_WIDTH-1:0]   sp;
  logic                  err;
  logic [2:0]            op_q;
  logic                  res_vld;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_err;
  logic [DATA_WIDTH-1:0] alu_y;

  logic       accept;
  logic [2:0] opc;
  logic       is_push;
  logic       is_bin;
  logic       is_end;
  logic       sp_full;
  logic       sp_lt2;
  logic       sp_one;
  logic       fail_end;

  assign bus.instr_ready  = (state == S_RUN) || (state == S_DRAIN);
  assign bus.result_valid = res_vld;
  assign bus.result       = res;
  assign bus.result_error = res_err;

  assign accept  = bus.instr_valid && bus.instr_ready;
  assign opc     = bus.instr_opcode;
  assign is_push = is_push_op(opc);
  assign is_bin  = is_bin_op(opc);
  assign is_end  = (opc == OP_END);
  assign sp_full = (sp == SP_WIDTH'(SIZE));
  assign sp_lt2  = (sp < SP_WIDTH'(2));
  assign sp_one  = (sp == SP_WIDTH'(1));

  // err is only ever set on the way into DRAIN, so any END
  // taken while draining lands here too.
  assign fail_end = accept && is_end && (err || !sp_one);

  stack_machine_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_alu (
    .op (op_q),
    .a  (mem_a_read_data),
    .b  (mem_b_read_data),
    .y  (alu_y)
  );

  always_comb begin
    mem_a_addr         = ADDR_WIDTH'(sp);
    mem_b_addr         = ADDR_WIDTH'(sp - SP_WIDTH'(2));
    mem_a_write_enable = 1'b0;
    mem_a_write_data   = bus.instr_imm;
    unique case (state)
      S_RUN: begin
        if (accept) begin
          unique case (1'b1)
            is_push: begin
              mem_a_write_enable = !sp_full;
              if (opc == OP_PUSH_X) mem_a_write_data = x;
            end
            is_bin:  mem_a_addr = ADDR_WIDTH'(sp - SP_WIDTH'(1));
            is_end:  mem_a_addr = '0;
            default: ;
          endcase
        end
      end
      S_BINOP: begin
        mem_a_addr         = ADDR_WIDTH'(sp - SP_WIDTH'(2));
        mem_a_write_enable = 1'b1;
        mem_a_write_data   = alu_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      sp      <= '0;
      err     <= 1'b0;
      op_q    <= OP_ADD;
      res_vld <= 1'b0;
      res     <= '0;
      res_err <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      if (fail_end) begin
        res     <= '0;
        res_err <= 1'b1;
        res_vld <= 1'b1;
        sp      <= '0;
        err     <= 1'b0;
        state   <= S_RUN;
      end else begin
        unique case (state)
          S_RUN: begin
            if (accept) begin
              unique case (1'b1)
                is_push: begin
                  if (sp_full) begin
                    err   <= 1'b1;
                    state <= S_DRAIN;
                  end else begin
                    sp <= sp + SP_WIDTH'(1);
                  end
                end
                is_bin: begin
                  if (sp_lt2) begin
                    err   <= 1'b1;
                    state <= S_DRAIN;
                  end else begin
                    op_q  <= opc;
                    state <= S_BINOP;
                  end
                end
                is_end:  state <= S_ENDRD;
                default: begin
                  err   <= 1'b1;
                  state <= S_DRAIN;
                end
              endcase
            end
          end
          S_BINOP: begin
            sp    <= sp - SP_WIDTH'(1);
            state <= S_RUN;
          end
          S_ENDRD: begin
            res     <= mem_a_read_data;
            res_err <= 1'b0;
            res_vld <= 1'b1;
            sp      <= '0;
            state   <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/stack_machine_core.md
Name: stack_machine_core

Overview:
Executes one RPN expression program per evaluation of f(x) for the function plotter, using the dual-port stack memory as operand storage. Instructions arrive as a valid/ready stream. PUSH instructions write through port A. Binary ops read the top two entries in one cycle, top through port A and second through port B, then write the result back through port A. At END the block emits one result word, or an error flag, to the plot stage downstream.

Parameters:
DATA_WIDTH, 16, word width: stack entries, immediates, x, result
SIZE, 64, stack depth in entries; must match the stack memory instance
FRAC_BITS, 8, fractional bits of signed fixed-point format
(local) ADDR_WIDTH = $clog2(SIZE); SP_WIDTH = ADDR_WIDTH+1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  instruction accepted when valid&ready
instr_opcode  in  3  opcode
instr_imm  in  DATA_WIDTH  immediate for PUSH_IMM
x  in  DATA_WIDTH  argument; held stable for whole program
result_valid  out  1  one-cycle pulse per END
result  out  DATA_WIDTH  evaluated value; 0 on error
result_error  out  1  qualifies result_valid
mem_a_addr  out  ADDR_WIDTH  to stack memory port A
mem_a_write_enable  out  1
mem_a_write_data  out  DATA_WIDTH
mem_a_read_data  in  DATA_WIDTH  1-cycle registered read, valid only when write_enable was low
mem_b_addr  out  ADDR_WIDTH  to stack memory port B
mem_b_read_data  in  DATA_WIDTH  1-cycle registered read

Behaviour:
- Reset: sp=0, state=RUN, err=0, result_valid=0, result=0, result_error=0. Memory is not cleared. Reset mid-program abandons the program. The first instruction after reset starts a new program.
- Opcodes: 0 PUSH_IMM, 1 PUSH_X, 2 ADD, 3 SUB, 4 MUL, 7 END. Codes 5 and 6 are illegal and raise an error.
- States:
  - RUN: instr_ready=1.
  - BINOP: instr_ready=0.
  - ENDRD: instr_ready=0.
  - DRAIN: instr_ready=1.
- Memory address and write ports are combinational from state/sp/instr. mem_a_write_enable is 0 unless stated below.
- RUN, accept PUSH_IMM or PUSH_X:
  - If sp==SIZE: set err and go to DRAIN.
  - Otherwise write imm or x at addr sp in the same cycle, sp+=1. One instruction per cycle.
- RUN, accept ADD/SUB/MUL:
  - If sp<2: set err and go to DRAIN.
  - Otherwise drive a_addr=sp-1 and b_addr=sp-2 with write_enable=0, latch the opcode, and go to BINOP.
- BINOP: compute with a=mem_a_read_data (top) and b=mem_b_read_data (second).
  - ADD: b+a. SUB: b-a. Both wrap modulo 2^DATA_WIDTH.
  - MUL: signed 2*DATA_WIDTH product, arithmetic shift right by FRAC_BITS, truncated to DATA_WIDTH (wraps, no saturation).
  - Write the result at addr sp-2, sp-=1, return to RUN. A binary op costs 2 cycles.
- RUN, accept END:
  - If sp!=1: go directly to the error result (below).
  - Otherwise drive a_addr=0 as a read and go to ENDRD.
- ENDRD: register result=mem_a_read_data, result_error=0, result_valid=1; sp=0; go to RUN. result_valid is high 2 cycles after END acceptance.
- Illegal opcode in RUN: set err, go to DRAIN.
- DRAIN: accept and discard instructions with no memory writes. On END, do the error result.
- Error result: registered result=0, result_error=1, result_valid=1 on the cycle after END acceptance; sp=0, err=0, state=RUN.
- result_valid is a single-cycle pulse; there is no downstream backpressure. result and result_error hold their value until the next pulse.
- instr_valid held high while instr_ready=0 must not cause a double accept. Instruction fields are only sampled on accept.

Decomposition:
- stack_machine_pkg: opcode localparams, state encoding, Q-format helpers (FRAC_BITS default).
- Sub-module stack_machine_alu: combinational ADD/SUB/MUL with fixed-point shift/truncate, parameterised by DATA_WIDTH and FRAC_BITS.
- Core holds the FSM, sp and the memory port muxing.
- The bench instantiates core + stack_machine_mem together.

Test Plan (DATA_WIDTH=16, FRAC_BITS=8):
1. x=0x0300 (3.0); program PUSH_X, PUSH_X, MUL, PUSH_IMM 0x0100, ADD, END -> result_valid once, result=0x0A00, result_error=0, sp back to 0.
2. PUSH_IMM 0x0500, PUSH_IMM 0x0200, SUB, END -> 0x0300 (operand order b-a). Also PUSH_IMM 0x7F00, PUSH_IMM 0x0200, ADD, END -> 0x8100 (wrap).
3. PUSH_IMM 0x0100, ADD, PUSH_IMM 0x0100, END -> error result: result=0, result_error=1. DRAIN must discard the trailing PUSH with no memory write. Illegal opcode 5 gives the same outcome.
4. SIZE=4: five PUSH_IMM then END -> error. The fifth push does not write memory.
5. instr_valid held high continuously with random stalls -> instr_ready low in BINOP/ENDRD, each instruction accepted exactly once, END-to-result_valid latency exactly 2 cycles.
6. rst asserted after PUSH_X, PUSH_X; then program PUSH_IMM 0x0200, END -> result=0x0200, no error (sp reset to 0).
